// File: rtl/apb_interconnect.sv
// Single-master, five-slave APB3 interconnect: address decode, select/enable
// fan-out, response mux, unmapped-address error and stalled-access timeout.
module apb_interconnect #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] SRAM_BASE      = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] SYSTEM_BASE    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] UART_BASE      = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] INTC_BASE      = 32'h1000_1000,
    parameter logic [ADDR_WIDTH-1:0] TIMER_BASE     = 32'h1000_2000,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] m_paddr,
    input  logic [DATA_WIDTH-1:0] m_pwdata,
    output logic [DATA_WIDTH-1:0] m_prdata,
    input  logic                  m_psel,
    input  logic                  m_penable,
    input  logic                  m_pwrite,
    input  logic [3:0]            m_pstb,
    output logic                  m_pready,
    output logic                  m_perr,
    output logic                  sram_sel,
    output logic                  sram_enable,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    input  logic                  sram_ready,
    input  logic                  sram_perr,
    output logic                  uart_sel,
    output logic                  uart_enable,
    input  logic [DATA_WIDTH-1:0] uart_rdata,
    input  logic                  uart_ready,
    input  logic                  uart_perr,
    output logic                  system_sel,
    output logic                  system_enable,
    input  logic [DATA_WIDTH-1:0] system_rdata,
    input  logic                  system_ready,
    input  logic                  system_perr,
    output logic                  intc_sel,
    output logic                  intc_enable,
    input  logic [DATA_WIDTH-1:0] intc_rdata,
    input  logic                  intc_ready,
    input  logic                  intc_perr,
    output logic                  timer_sel,
    output logic                  timer_enable,
    input  logic [DATA_WIDTH-1:0] timer_rdata,
    input  logic                  timer_ready,
    input  logic                  timer_perr
);

    localparam logic [ADDR_WIDTH-1:0] SRAM_MASK   = 32'hFF00_0000;
    localparam logic [ADDR_WIDTH-1:0] SYSTEM_MASK = 32'hFFFF_0000;
    localparam logic [ADDR_WIDTH-1:0] UART_MASK   = 32'hFFFF_F000;
    localparam logic [ADDR_WIDTH-1:0] INTC_MASK   = 32'hFFFF_F000;
    localparam logic [ADDR_WIDTH-1:0] TIMER_MASK  = 32'hFFFF_F000;

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic [2:0] IDX_SLAVES   = 3'd5;
    localparam logic [2:0] IDX_UNMAPPED = 3'd5;
    localparam logic [2:0] IDX_NONE     = 3'd7;

    logic [0:0]            state;
    logic [2:0]            lat_idx;
    logic [2:0]            dec_idx;
    logic [CW-1:0]         cnt;
    logic [4:0]            hit;
    logic [4:0]            sel_v;
    logic [4:0]            en_v;
    logic [4:0]            ready_v;
    logic [4:0]            perr_v;
    logic [DATA_WIDTH-1:0] rdata_v [5];
    logic                  cur_ready;
    logic                  unused_shared;

    // Write data, direction and strobes reach the slaves on shared wires.
    assign unused_shared = ^{m_pwdata, m_pwrite, m_pstb};

    assign hit[0] = (m_paddr & SRAM_MASK)   == SRAM_BASE;
    assign hit[1] = (m_paddr & UART_MASK)   == UART_BASE;
    assign hit[2] = (m_paddr & SYSTEM_MASK) == SYSTEM_BASE;
    assign hit[3] = (m_paddr & INTC_MASK)   == INTC_BASE;
    assign hit[4] = (m_paddr & TIMER_MASK)  == TIMER_BASE;

    assign ready_v = {timer_ready, intc_ready, system_ready, uart_ready, sram_ready};
    assign perr_v  = {timer_perr, intc_perr, system_perr, uart_perr, sram_perr};
    assign rdata_v[0] = sram_rdata;
    assign rdata_v[1] = uart_rdata;
    assign rdata_v[2] = system_rdata;
    assign rdata_v[3] = intc_rdata;
    assign rdata_v[4] = timer_rdata;

    assign {timer_sel, intc_sel, system_sel, uart_sel, sram_sel} = sel_v;
    assign {timer_enable, intc_enable, system_enable, uart_enable, sram_enable} = en_v;

    always_comb begin
        dec_idx = IDX_UNMAPPED;
        for (int unsigned i = 0; i < 5; i++) begin
            if (hit[i]) dec_idx = 3'(i);
        end
    end

    assign cur_ready = (lat_idx < IDX_SLAVES) ? ready_v[lat_idx] : 1'b0;

    // Outputs are gated by rst_n so they clear the moment reset asserts.
    always_comb begin
        sel_v    = '0;
        en_v     = '0;
        m_prdata = '0;
        m_pready = 1'b0;
        m_perr   = 1'b0;
        if (rst_n) begin
            if (state == IDLE) begin
                sel_v = m_psel ? hit : '0;
            end else if (m_psel) begin
                if (lat_idx == IDX_UNMAPPED) begin
                    m_pready = 1'b1;
                    m_perr   = 1'b1;
                end else if (lat_idx < IDX_SLAVES) begin
                    sel_v[lat_idx] = 1'b1;
                    en_v[lat_idx]  = m_penable;
                    if (cur_ready) begin
                        m_prdata = rdata_v[lat_idx];
                        m_pready = 1'b1;
                        m_perr   = perr_v[lat_idx];
                    end else if (m_penable && cnt == CNT_LAST) begin
                        m_pready = 1'b1;
                        m_perr   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_idx <= IDX_NONE;
            cnt     <= '0;
        end else if (state == IDLE) begin
            if (m_psel && !m_penable) begin
                state   <= ACCESS;
                lat_idx <= dec_idx;
                cnt     <= '0;
            end
        end else begin
            if (!m_psel || m_pready) begin
                state   <= IDLE;
                lat_idx <= IDX_NONE;
                cnt     <= '0;
            end else if (m_penable && !cur_ready) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_interconnect.sv
// Scoreboard bench for apb_interconnect: decode, wait states, errors,
// timeout, back-to-back transfers and asynchronous reset.
module tb_apb_interconnect;

    localparam int TIMEOUT = 256;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m_paddr = '0;
    logic [31:0] m_pwdata = '0;
    logic [31:0] m_prdata;
    logic        m_psel = 1'b0;
    logic        m_penable = 1'b0;
    logic        m_pwrite = 1'b0;
    logic [3:0]  m_pstb = 4'hF;
    logic        m_pready;
    logic        m_perr;
    logic        sram_sel, uart_sel, system_sel, intc_sel, timer_sel;
    logic        sram_enable, uart_enable, system_enable, intc_enable, timer_enable;
    logic [31:0] s_rdata [5];
    logic [4:0]  s_ready = '0;
    logic [4:0]  s_perr = '0;
    logic [4:0]  s_sel;
    logic [4:0]  s_en;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    assign s_sel = {timer_sel, intc_sel, system_sel, uart_sel, sram_sel};
    assign s_en  = {timer_enable, intc_enable, system_enable, uart_enable, sram_enable};

    always #5 clk = ~clk;

    apb_interconnect #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_pstb(m_pstb),
        .m_pready(m_pready), .m_perr(m_perr),
        .sram_sel(sram_sel), .sram_enable(sram_enable), .sram_rdata(s_rdata[0]),
        .sram_ready(s_ready[0]), .sram_perr(s_perr[0]),
        .uart_sel(uart_sel), .uart_enable(uart_enable), .uart_rdata(s_rdata[1]),
        .uart_ready(s_ready[1]), .uart_perr(s_perr[1]),
        .system_sel(system_sel), .system_enable(system_enable), .system_rdata(s_rdata[2]),
        .system_ready(s_ready[2]), .system_perr(s_perr[2]),
        .intc_sel(intc_sel), .intc_enable(intc_enable), .intc_rdata(s_rdata[3]),
        .intc_ready(s_ready[3]), .intc_perr(s_perr[3]),
        .timer_sel(timer_sel), .timer_enable(timer_enable), .timer_rdata(s_rdata[4]),
        .timer_ready(s_ready[4]), .timer_perr(s_perr[4])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave order: 0 sram, 1 uart, 2 system, 3 intc, 4 timer, 5 unmapped.
    function automatic int model_idx(input logic [31:0] a);
        if ((a & 32'hFF00_0000) == 32'h8000_0000) return 0;
        if ((a & 32'hFFFF_F000) == 32'h1000_0000) return 1;
        if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 2;
        if ((a & 32'hFFFF_F000) == 32'h1000_1000) return 3;
        if ((a & 32'hFFFF_F000) == 32'h1000_2000) return 4;
        return 5;
    endfunction

    task automatic xfer(input logic [31:0] addr, input logic wr, input int wait_n,
                        input logic [31:0] rdata, input logic serr, input bit stuck);
        int         idx;
        logic [4:0] onehot;
        exp_t       e;
        bit         done;
        idx    = model_idx(addr);
        onehot = (idx < 5) ? 5'(1 << idx) : 5'b0;
        done   = 0;
        e.data   = (idx >= 5 || stuck) ? 32'h0 : rdata;
        e.err    = (idx >= 5 || stuck) ? 1'b1 : serr;
        e.cycles = (idx >= 5) ? 1 : (stuck ? TIMEOUT : wait_n + 1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            s_rdata[i] = (i == idx) ? rdata : (32'hBAD0_0000 | 32'(i));
            s_perr[i]  = (i == idx) ? serr : 1'b1;
            s_ready[i] = (i != idx);
        end
        m_paddr = addr; m_pwrite = wr; m_pwdata = $urandom;
        m_psel = 1'b1; m_penable = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        check_eq("setup_sel", 64'(s_sel), 64'(onehot));
        check_eq("setup_en", 64'(s_en), 64'h0);
        check_eq("setup_ready", 64'(m_pready), 64'h0);
        for (int k = 1; k <= TIMEOUT + 8 && !done; k++) begin
            @(posedge clk); #1;
            m_penable = 1'b1;
            if (idx < 5) s_ready[idx] = !stuck && (k > wait_n);
            @(negedge clk);
            check_eq("acc_sel", 64'(s_sel), 64'(onehot));
            check_eq("acc_en", 64'(s_en), 64'(onehot));
            if (m_pready) begin
                done = 1;
                e = sb.pop_front();
                check_eq("rdata", 64'(m_prdata), 64'(e.data));
                check_eq("perr", 64'(m_perr), 64'(e.err));
                check_eq("latency", 64'(k), 64'(e.cycles));
            end
        end
        if (!done) begin
            check_eq("ready_bound", 64'(m_pready), 64'h1);
            void'(sb.pop_front());
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        @(negedge clk);
        check_eq("idle_sel", 64'(s_sel), 64'h0);
        check_eq("idle_en", 64'(s_en), 64'h0);
        check_eq("idle_ready", 64'(m_pready), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) s_rdata[i] = '0;
        // Select with a mapped address while reset is held: nothing may leak out.
        m_psel = 1'b1; m_paddr = 32'h8000_0010;
        @(negedge clk);
        check_eq("reset_outs", {s_sel, s_en, m_pready, m_perr, m_prdata}, 64'h0);
        @(posedge clk); #1;
        m_psel = 1'b0; rst_n = 1'b1;

        xfer(32'h8000_0010, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 0); idle();
        xfer(32'h1000_0000, 1'b1, 3, 32'h0000_00A5, 1'b0, 0); idle();
        xfer(32'h4000_0000, 1'b0, 0, 32'h1111_1111, 1'b0, 0); idle();
        xfer(32'h1000_2004, 1'b0, 0, 32'h2222_2222, 1'b0, 1); idle();
        xfer(32'h1000_1000, 1'b0, 1, 32'h1234_5678, 1'b0, 0); idle();
        xfer(32'h1000_1008, 1'b0, 0, 32'hCAFE_F00D, 1'b1, 0); idle();

        // Back-to-back transfers at region edges, then unmapped neighbours.
        xfer(32'h0000_FFFC, 1'b0, 0, 32'h5A5A_0001, 1'b0, 0);
        xfer(32'h80FF_FFFC, 1'b1, 2, 32'h5A5A_0002, 1'b0, 0);
        xfer(32'h1000_2FFC, 1'b0, 0, 32'h5A5A_0003, 1'b0, 0);
        xfer(32'h0001_0000, 1'b0, 0, 32'h5A5A_0004, 1'b0, 0);
        xfer(32'h8100_0000, 1'b0, 0, 32'h5A5A_0005, 1'b0, 0);
        xfer(32'h1000_3000, 1'b0, 0, 32'h5A5A_0006, 1'b0, 0); idle();

        // Enable without select in IDLE must not produce any enable.
        @(posedge clk); #1;
        m_paddr = 32'h8000_0000; m_psel = 1'b0; m_penable = 1'b1;
        @(negedge clk);
        check_eq("idle_penable_en", 64'(s_en), 64'h0);
        check_eq("idle_penable_sel", 64'(s_sel), 64'h0);
        idle();

        // Reset asserted in the middle of a stalled sram access.
        @(posedge clk); #1;
        s_ready = '0; s_rdata[0] = 32'h7777_7777;
        m_paddr = 32'h8000_0100; m_psel = 1'b1; m_penable = 1'b0;
        @(posedge clk); #1;
        m_penable = 1'b1;
        @(negedge clk);
        check_eq("mid_en", 64'(s_en), 64'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_outs", {s_sel, s_en, m_pready, m_perr, m_prdata}, 64'h0);
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0; rst_n = 1'b1;
        xfer(32'h8000_0200, 1'b0, 1, 32'h0BAD_CAFE, 1'b0, 0); idle();

        check_eq("sb_empty", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
